// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Bundle of the requester handshakes (instruction fetch and
//               data access) and the board SRAM pins served by
//               mem_bus_arbiter.
//   slave  modport : arbiter side (samples requests and ram_din, drives
//                    ready/data and the SRAM control/address/data pins)
//   master modport : environment side (CPU requesters plus SRAM)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Instruction fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_data;

    // Data access requester
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    // Board SRAM
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_dout_en;
    logic [DATA_W-1:0] ram_din;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;

    modport slave (
        input  if_req, if_addr, mem_re, mem_we, mem_addr, mem_wdata, ram_din,
        output if_ready, if_data, mem_ready, mem_rdata,
               ram_addr, ram_dout, ram_dout_en, ram_ce_n, ram_oe_n, ram_we_n
    );

    modport master (
        output if_req, if_addr, mem_re, mem_we, mem_addr, mem_wdata, ram_din,
        input  if_ready, if_data, mem_ready, mem_rdata,
               ram_addr, ram_dout, ram_dout_en, ram_ce_n, ram_oe_n, ram_we_n
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one single-port asynchronous SRAM between the CPU's
//               instruction fetch (IF) and data access (MEM) ports and
//               sequences the SRAM CE/OE/WE timing. Every output is a flop.
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : mem_bus_arbiter_if.slave
//            if_req/if_addr        -> if_ready pulse + if_data
//            mem_re/mem_we/...     -> mem_ready pulse + mem_rdata
//            ram_addr/ram_dout/ram_dout_en/ram_ce_n/ram_oe_n/ram_we_n out,
//            ram_din in
//   Read  : IDLE -> RD -> IDLE(ready)              (2 cycles)
//   Write : IDLE -> WR1 -> WR2 -> WR3 -> IDLE(ready) (4 cycles)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_arbiter_if.slave    bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR1  = 3'd2,
        ST_WR2  = 3'd3,
        ST_WR3  = 3'd4
    } state_t;

    state_t            state_q,       state_d;
    logic              sel_mem_q,     sel_mem_d;     // owner of the read in flight
    logic [CNT_W-1:0]  streak_q,      streak_d;      // MEM grants while IF waits
    logic [ADDR_W-1:0] ram_addr_q,    ram_addr_d;
    logic [DATA_W-1:0] ram_dout_q,    ram_dout_d;
    logic              ram_dout_en_q, ram_dout_en_d;
    logic              ram_ce_n_q,    ram_ce_n_d;
    logic              ram_oe_n_q,    ram_oe_n_d;
    logic              ram_we_n_q,    ram_we_n_d;
    logic              if_ready_q,    if_ready_d;
    logic [DATA_W-1:0] if_data_q,     if_data_d;
    logic              mem_ready_q,   mem_ready_d;
    logic [DATA_W-1:0] mem_rdata_q,   mem_rdata_d;

    logic w_mem_want;
    logic w_if_win;

    assign w_mem_want = bus.mem_re | bus.mem_we;
    // IF wins when MEM is quiet, or when it has been passed over too often.
    assign w_if_win   = bus.if_req & (~w_mem_want | (streak_q == STREAK_MAX));

    // The *_d values are what the pins/registers show in the NEXT cycle,
    // so each transition below sets up the control levels of the state it
    // enters.
    always_comb begin
        state_d       = state_q;
        sel_mem_d     = sel_mem_q;
        streak_d      = streak_q;
        ram_addr_d    = ram_addr_q;
        ram_dout_d    = ram_dout_q;
        ram_dout_en_d = ram_dout_en_q;
        ram_ce_n_d    = ram_ce_n_q;
        ram_oe_n_d    = ram_oe_n_q;
        ram_we_n_d    = ram_we_n_q;
        if_ready_d    = 1'b0;
        if_data_d     = if_data_q;
        mem_ready_d   = 1'b0;
        mem_rdata_d   = mem_rdata_q;

        if (!bus.if_req) begin
            streak_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                ram_ce_n_d    = 1'b1;
                ram_oe_n_d    = 1'b1;
                ram_we_n_d    = 1'b1;
                ram_dout_en_d = 1'b0;
                if (w_if_win) begin
                    streak_d   = '0;
                    sel_mem_d  = 1'b0;
                    ram_addr_d = bus.if_addr;
                    ram_ce_n_d = 1'b0;
                    ram_oe_n_d = 1'b0;
                    state_d    = ST_RD;
                end else if (w_mem_want) begin
                    sel_mem_d  = 1'b1;
                    ram_addr_d = bus.mem_addr;
                    ram_ce_n_d = 1'b0;
                    // IF cannot be at the limit here, otherwise it would have won.
                    if (bus.if_req) begin
                        streak_d = streak_q + 1'b1;
                    end
                    if (bus.mem_we) begin
                        ram_dout_d    = bus.mem_wdata;
                        ram_dout_en_d = 1'b1;
                        state_d       = ST_WR1;
                    end else begin
                        ram_oe_n_d = 1'b0;
                        state_d    = ST_RD;
                    end
                end
            end

            ST_RD: begin
                ram_ce_n_d = 1'b1;
                ram_oe_n_d = 1'b1;
                state_d    = ST_IDLE;
                if (sel_mem_q) begin
                    mem_rdata_d = bus.ram_din;
                    mem_ready_d = 1'b1;
                end else begin
                    if_data_d  = bus.ram_din;
                    if_ready_d = 1'b1;
                end
            end

            ST_WR1: begin
                ram_we_n_d = 1'b0;
                state_d    = ST_WR2;
            end

            ST_WR2: begin
                // Address/data stay driven one more cycle after WE rises.
                ram_we_n_d = 1'b1;
                state_d    = ST_WR3;
            end

            ST_WR3: begin
                ram_ce_n_d    = 1'b1;
                ram_dout_en_d = 1'b0;
                mem_ready_d   = 1'b1;
                state_d       = ST_IDLE;
            end

            default: begin
                ram_ce_n_d    = 1'b1;
                ram_oe_n_d    = 1'b1;
                ram_we_n_d    = 1'b1;
                ram_dout_en_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            sel_mem_q     <= 1'b0;
            streak_q      <= '0;
            ram_addr_q    <= '0;
            ram_dout_q    <= '0;
            ram_dout_en_q <= 1'b0;
            ram_ce_n_q    <= 1'b1;
            ram_oe_n_q    <= 1'b1;
            ram_we_n_q    <= 1'b1;
            if_ready_q    <= 1'b0;
            if_data_q     <= '0;
            mem_ready_q   <= 1'b0;
            mem_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            sel_mem_q     <= sel_mem_d;
            streak_q      <= streak_d;
            ram_addr_q    <= ram_addr_d;
            ram_dout_q    <= ram_dout_d;
            ram_dout_en_q <= ram_dout_en_d;
            ram_ce_n_q    <= ram_ce_n_d;
            ram_oe_n_q    <= ram_oe_n_d;
            ram_we_n_q    <= ram_we_n_d;
            if_ready_q    <= if_ready_d;
            if_data_q     <= if_data_d;
            mem_ready_q   <= mem_ready_d;
            mem_rdata_q   <= mem_rdata_d;
        end
    end

    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_dout    = ram_dout_q;
    assign bus.ram_dout_en = ram_dout_en_q;
    assign bus.ram_ce_n    = ram_ce_n_q;
    assign bus.ram_oe_n    = ram_oe_n_q;
    assign bus.ram_we_n    = ram_we_n_q;
    assign bus.if_ready    = if_ready_q;
    assign bus.if_data     = if_data_q;
    assign bus.mem_ready   = mem_ready_q;
    assign bus.mem_rdata   = mem_rdata_q;

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences the single-port board SRAM and shares it between instruction fetch (IF) and data access (MEM) of the 16-bit CPU.
- Replaces the combinational simulation instruction ROM once instructions and data live in the same physical RAM.
- Grants one requester at a time and generates SRAM OE/WE/CE timing.
- Requesters see a registered ready/data handshake.

Parameters:
- ADDR_W, 16, width of PC bus / memory address.
- DATA_W, 16, width of instruction/data word.
- STARVE_LIMIT, 4, consecutive MEM grants while IF waits before IF is forced one grant.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request.
- if_addr  in  ADDR_W  fetch address (PC).
- if_ready  out  1  one-cycle pulse, if_data valid.
- if_data  out  DATA_W  fetched instruction, registered.
- mem_re  in  1  data read request.
- mem_we  in  1  data write request.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  write data.
- mem_ready  out  1  one-cycle pulse, access complete (mem_rdata valid on reads).
- mem_rdata  out  DATA_W  read data, registered.
- ram_addr  out  ADDR_W  SRAM address, registered.
- ram_dout  out  DATA_W  data driven to SRAM, registered.
- ram_dout_en  out  1  top-level tristate enable for ram_dout.
- ram_din  in  DATA_W  data from SRAM.
- ram_ce_n  out  1  SRAM chip enable, active low.
- ram_oe_n  out  1  SRAM output enable, active low.
- ram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- States: IDLE, RD, WR1, WR2, WR3.
- All outputs are registered.
- Reset (async, any state): state=IDLE; ram_ce_n=ram_oe_n=ram_we_n=1; ram_dout_en=0; ram_addr=0; ram_dout=0; if_ready=mem_ready=0; if_data=mem_rdata=0; streak counter=0. An in-flight access is abandoned and no ready is issued.
- Requests are sampled only at the clock edge ending an IDLE cycle. A requester holds req/addr/wdata stable until its ready pulse.
- req/addr present during the ready cycle itself is sampled as a new request, which allows back-to-back accesses.
- Arbitration in IDLE:
  - MEM has priority.
  - If both request and the streak counter equals STARVE_LIMIT, IF wins and the counter clears.
  - The counter increments on each MEM grant while if_req=1, saturates at STARVE_LIMIT, and clears on any IF grant or when if_req=0.
- mem_we=1 selects a write regardless of mem_re. mem_re=1 with mem_we=0 selects a read.
- Read (IF or MEM), accepted at edge ending cycle N:
  - Cycle N+1 (RD): ram_addr=address, ce_n=0, oe_n=0, we_n=1, dout_en=0. ram_din is captured into the granted requester's data register at the edge ending N+1.
  - Cycle N+2: IDLE with ready=1 for one cycle and ce_n/oe_n=1.
  - Read latency is 2 cycles from acceptance.
- Write, accepted at edge ending cycle N:
  - N+1 WR1: addr and dout driven, dout_en=1, ce_n=0, we_n=1.
  - N+2 WR2: we_n=0.
  - N+3 WR3: we_n=1, addr/dout/dout_en held (hold time).
  - N+4: IDLE with mem_ready=1, dout_en=0, ce_n=1.
  - oe_n stays 1 throughout a write.
- A non-granted requester is not acknowledged and keeps waiting. No request is ever dropped.
- if_ready and mem_ready are never high in the same cycle.
- ram_oe_n=0 and ram_dout_en=1 are never high in the same cycle.
- Address and data are used at full ADDR_W/DATA_W width with no wrap logic; the address is passed through unchanged.

Test Plan:
- Reset, then if_req=1, if_addr=0x0003, ram_din=0x7010 → RD at N+1 with oe_n=0, ram_addr=0x0003; if_ready=1 and if_data=0x7010 at N+2.
- mem_we=1, addr=0x8000, wdata=0xBEEF → WR1/WR2/WR3 sequence; we_n low only at N+2; dout=0xBEEF, dout_en=1 for N+1..N+3; mem_ready at N+4.
- if_req and mem_re both held high → MEM served first; IF served after the MEM ready. With mem_re held high continuously, IF is granted after exactly STARVE_LIMIT=4 MEM grants.
- if_req held high with incrementing if_addr 0..3 updated on each if_ready → four reads back-to-back, one if_ready every 2 cycles, data matches the SRAM model.
- Async rst low during WR2 → we_n, ce_n, dout_en go inactive immediately without waiting for clk; no mem_ready after release; next request restarts cleanly from IDLE.
- mem_re=1 and mem_we=1 together → write sequence performed; oe_n never asserted.
